// File: rtl/axil_pkg.sv
// axil_pkg: shared types for the AXI4-Lite master engine.
// Response codes, engine state encodings, default protection.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_wdog.sv
// axil_wdog: busy-cycle counter with a sticky timeout flag.
// Counter saturates at the limit and clears whenever busy drops.
module axil_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic busy,
  output logic tmo
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  // count busy cycles, latch the flag once the limit is reached
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt <= '0;
      tmo <= 1'b0;
    end else begin
      if (!busy) begin
        cnt <= '0;
      end else if (cnt != LIMIT) begin
        cnt <= cnt + CW'(1);
      end
      if (cnt == LIMIT) begin
        tmo <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_master_ctrl.sv
// axil_master_ctrl: request/response to AXI4-Lite master engine.
// Optional watchdog built when AXIL_MASTER_WDOG_EN is defined.
module axil_master_ctrl
  import axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 1024,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic [STRB_W-1:0] wr_req_strb,
  input  logic [2:0]        wr_req_prot,
  output logic              wr_done,
  output logic [1:0]        wr_resp,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic [2:0]        rd_req_prot,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_resp,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWPROT,
  output logic              WVALID,
  input  logic              WREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [2:0]        ARPROT,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  output logic              tmo_err
);

  wr_state_t w_st, w_nx;
  rd_state_t r_st, r_nx;
  logic aw_done, w_done;
  logic wr_acc, aw_hs, w_hs, b_hs;
  logic rd_acc, r_hs;

  // state registers for both engines
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_st <= W_IDLE;
      r_st <= R_IDLE;
    end else begin
      w_st <= w_nx;
      r_st <= r_nx;
    end
  end

  // write engine: next state and channel controls
  always_comb begin
    w_nx = w_st;
    wr_req_ready = 1'b0;
    AWVALID = 1'b0;
    WVALID = 1'b0;
    BREADY = 1'b0;
    unique case (w_st)
      W_IDLE: begin
        wr_req_ready = 1'b1;
        if (wr_req_valid) w_nx = W_REQ;
      end
      W_REQ: begin
        AWVALID = !aw_done;
        WVALID = !w_done;
        if ((aw_done || AWREADY) &&
            (w_done || WREADY)) begin
          w_nx = W_RESP;
        end
      end
      W_RESP: begin
        BREADY = 1'b1;
        if (BVALID) w_nx = W_IDLE;
      end
      default: w_nx = W_IDLE;
    endcase
    wr_acc = wr_req_valid && wr_req_ready;
    aw_hs = AWVALID && AWREADY;
    w_hs = WVALID && WREADY;
    b_hs = BVALID && BREADY;
  end

  // write engine: captured command, flags, response
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      AWADDR <= '0;
      AWPROT <= PROT_DEFAULT;
      WDATA <= '0;
      WSTRB <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      wr_resp <= OKAY;
      wr_done <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      if (wr_acc) begin
        AWADDR <= wr_req_addr;
        AWPROT <= wr_req_prot;
        WDATA <= wr_req_data;
        WSTRB <= wr_req_strb;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (b_hs) begin
        wr_resp <= BRESP;
        wr_done <= 1'b1;
      end
    end
  end

  // read engine: next state and channel controls
  always_comb begin
    r_nx = r_st;
    rd_req_ready = 1'b0;
    ARVALID = 1'b0;
    RREADY = 1'b0;
    unique case (r_st)
      R_IDLE: begin
        rd_req_ready = 1'b1;
        if (rd_req_valid) r_nx = R_ADDR;
      end
      R_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) r_nx = R_DATA;
      end
      R_DATA: begin
        RREADY = 1'b1;
        if (RVALID) r_nx = R_IDLE;
      end
      default: r_nx = R_IDLE;
    endcase
    rd_acc = rd_req_valid && rd_req_ready;
    r_hs = RVALID && RREADY;
  end

  // read engine: captured command and returned data
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ARADDR <= '0;
      ARPROT <= PROT_DEFAULT;
      rd_data <= '0;
      rd_resp <= OKAY;
      rd_done <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (rd_acc) begin
        ARADDR <= rd_req_addr;
        ARPROT <= rd_req_prot;
      end
      if (r_hs) begin
        rd_data <= RDATA;
        rd_resp <= RRESP;
        rd_done <= 1'b1;
      end
    end
  end

`ifdef AXIL_MASTER_WDOG_EN
  logic w_tmo, r_tmo;

  axil_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog_wr (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .busy(w_st != W_IDLE),
    .tmo(w_tmo)
  );

  axil_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog_rd (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .busy(r_st != R_IDLE),
    .tmo(r_tmo)
  );

  assign tmo_err = w_tmo | r_tmo;
`else
  localparam int unused_tmo = TIMEOUT_CYC;
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_axil_master_ctrl.sv
// tb_axil_master_ctrl: scoreboard bench with a delay-programmable
// AXI4-Lite slave model driven on the falling edge.
`timescale 1ns/1ps
module tb_axil_master_ctrl;
  import axil_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TMO = 16;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic [SW-1:0] wr_req_strb;
  logic [2:0]    wr_req_prot;
  logic          wr_done;
  logic [1:0]    wr_resp;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [2:0]    rd_req_prot;
  logic          rd_done;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_resp;
  logic          AWVALID, AWREADY;
  logic [AW-1:0] AWADDR;
  logic [2:0]    AWPROT;
  logic          WVALID, WREADY;
  logic [DW-1:0] WDATA;
  logic [SW-1:0] WSTRB;
  logic          BVALID, BREADY;
  logic [1:0]    BRESP;
  logic          ARVALID, ARREADY;
  logic [AW-1:0] ARADDR;
  logic [2:0]    ARPROT;
  logic          RVALID, RREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          tmo_err;

  axil_master_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .wr_req_valid(wr_req_valid),
    .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data),
    .wr_req_strb(wr_req_strb),
    .wr_req_prot(wr_req_prot),
    .wr_done(wr_done), .wr_resp(wr_resp),
    .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr),
    .rd_req_prot(rd_req_prot),
    .rd_done(rd_done), .rd_data(rd_data),
    .rd_resp(rd_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY),
    .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY),
    .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY),
    .RDATA(RDATA), .RRESP(RRESP),
    .tmo_err(tmo_err)
  );

  typedef struct {
    logic [1:0] resp;
    int lat;
    int acc;
  } wexp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0] resp;
    int lat;
    int acc;
  } rexp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0] prot;
  } aexp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } dexp_t;

  wexp_t wr_q[$];
  rexp_t rd_q[$];
  aexp_t aw_q[$];
  aexp_t ar_q[$];
  dexp_t w_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // slave timing knobs (cycles of READY/VALID delay)
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  int b_dly = 0, r_dly = 0;
  logic [1:0] b_code = OKAY;
  logic [1:0] r_code = OKAY;
  logic [DW-1:0] r_word = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event want none", nm);
  endtask

  task automatic wr_cmd(input logic [AW-1:0] a,
                        input logic [DW-1:0] d,
                        input logic [SW-1:0] s,
                        input logic [2:0] p,
                        input logic [1:0] r,
                        input int lat,
                        input bit want_done,
                        output int acc);
    int n = 0;
    @(negedge ACLK);
    wr_req_valid = 1'b1;
    wr_req_addr = a;
    wr_req_data = d;
    wr_req_strb = s;
    wr_req_prot = p;
    while (!wr_req_ready && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    if (!wr_req_ready) begin
      fail_msg("wr_req accept timeout");
      wr_req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge ACLK);
    #1;
    acc = cyc;
    wr_req_valid = 1'b0;
    aw_q.push_back('{a, p});
    w_q.push_back('{d, s});
    if (want_done) wr_q.push_back('{r, lat, acc});
  endtask

  task automatic rd_cmd(input logic [AW-1:0] a,
                        input logic [2:0] p,
                        input logic [DW-1:0] d,
                        input logic [1:0] r,
                        input int lat,
                        output int acc);
    int n = 0;
    @(negedge ACLK);
    rd_req_valid = 1'b1;
    rd_req_addr = a;
    rd_req_prot = p;
    while (!rd_req_ready && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    if (!rd_req_ready) begin
      fail_msg("rd_req accept timeout");
      rd_req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge ACLK);
    #1;
    acc = cyc;
    rd_req_valid = 1'b0;
    ar_q.push_back('{a, p});
    rd_q.push_back('{d, r, lat, acc});
  endtask

  task automatic drain();
    int n = 0;
    while ((wr_q.size() != 0 || rd_q.size() != 0)
           && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      fail_msg("completion timeout");
      wr_q.delete();
      rd_q.delete();
    end
    @(negedge ACLK);
  endtask

  // response monitor: pops expectations on every done pulse
  initial begin
    wexp_t we;
    rexp_t re;
    forever begin
      @(negedge ACLK);
      if (wr_done) begin
        if (wr_q.size() == 0) begin
          fail_msg("wr_done unexpected");
        end else begin
          we = wr_q.pop_front();
          chk("wr_resp", 64'(wr_resp), 64'(we.resp));
          if (we.lat >= 0)
            chk("wr_latency", 64'(cyc - we.acc),
                64'(we.lat));
        end
      end
      if (rd_done) begin
        if (rd_q.size() == 0) begin
          fail_msg("rd_done unexpected");
        end else begin
          re = rd_q.pop_front();
          chk("rd_data", 64'(rd_data), 64'(re.data));
          chk("rd_resp", 64'(rd_resp), 64'(re.resp));
          if (re.lat >= 0)
            chk("rd_latency", 64'(cyc - re.acc),
                64'(re.lat));
        end
      end
    end
  end

  // slave model: handshakes seen at the last rising edge are
  // reconstructed from values held since the previous falling edge
  initial begin
    bit awv_s, wv_s, br_s, arv_s, rr_s;
    bit aw_f, w_f, b_f, ar_f, r_f;
    bit aw_got, w_got, b_pend, r_pend;
    int aw_c, w_c, ar_c, b_c, r_c;
    {awv_s, wv_s, br_s, arv_s, rr_s} = '0;
    {aw_got, w_got, b_pend, r_pend} = '0;
    {aw_c, w_c, ar_c, b_c, r_c} = '0;
    AWREADY = 0; WREADY = 0; ARREADY = 0;
    BVALID = 0; BRESP = 0;
    RVALID = 0; RDATA = 0; RRESP = 0;
    forever begin
      @(negedge ACLK);
      aw_f = awv_s && AWREADY;
      w_f = wv_s && WREADY;
      b_f = BVALID && br_s;
      ar_f = arv_s && ARREADY;
      r_f = RVALID && rr_s;
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; ARREADY = 0;
        BVALID = 0; RVALID = 0;
        {aw_got, w_got, b_pend, r_pend} = '0;
        {aw_c, w_c, ar_c, b_c, r_c} = '0;
        aw_q.delete();
        w_q.delete();
        ar_q.delete();
        {awv_s, wv_s, br_s, arv_s, rr_s} = '0;
      end else begin
        if (aw_f) begin
          chk("AWVALID drop", 64'(AWVALID), 0);
          aw_got = 1;
          aw_c = 0;
        end
        if (w_f) begin
          chk("WVALID drop", 64'(WVALID), 0);
          w_got = 1;
          w_c = 0;
        end
        if (ar_f) begin
          chk("ARVALID drop", 64'(ARVALID), 0);
          r_pend = 1;
          r_c = 0;
        end
        if (b_f) BVALID = 0;
        if (r_f) RVALID = 0;
        if (aw_got && w_got) begin
          aw_got = 0;
          w_got = 0;
          b_pend = 1;
          b_c = 0;
        end
        if (BREADY)
          chk("BREADY after AW+W",
              64'({AWVALID, WVALID}), 0);

        AWREADY = 0;
        if (AWVALID) begin
          if (aw_q.size() == 0) begin
            fail_msg("AWVALID no command");
          end else begin
            chk("AWADDR", 64'(AWADDR),
                64'(aw_q[0].addr));
            chk("AWPROT", 64'(AWPROT),
                64'(aw_q[0].prot));
            if (aw_c >= aw_dly) begin
              AWREADY = 1;
              aw_q.delete(0);
            end else aw_c++;
          end
        end

        WREADY = 0;
        if (WVALID) begin
          if (w_q.size() == 0) begin
            fail_msg("WVALID no command");
          end else begin
            chk("WDATA", 64'(WDATA),
                64'(w_q[0].data));
            chk("WSTRB", 64'(WSTRB),
                64'(w_q[0].strb));
            if (w_c >= w_dly) begin
              WREADY = 1;
              w_q.delete(0);
            end else w_c++;
          end
        end

        ARREADY = 0;
        if (ARVALID) begin
          if (ar_q.size() == 0) begin
            fail_msg("ARVALID no command");
          end else begin
            chk("ARADDR", 64'(ARADDR),
                64'(ar_q[0].addr));
            chk("ARPROT", 64'(ARPROT),
                64'(ar_q[0].prot));
            if (ar_c >= ar_dly) begin
              ARREADY = 1;
              ar_q.delete(0);
            end else ar_c++;
          end
        end

        if (b_pend && !BVALID) begin
          if (b_c >= b_dly) begin
            BVALID = 1;
            BRESP = b_code;
            b_pend = 0;
          end else b_c++;
        end

        if (r_pend && !RVALID) begin
          if (r_c >= r_dly) begin
            RVALID = 1;
            RDATA = r_word;
            RRESP = r_code;
            r_pend = 0;
          end else r_c++;
        end

        awv_s = AWVALID;
        wv_s = WVALID;
        br_s = BREADY;
        arv_s = ARVALID;
        rr_s = RREADY;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got hang want finish");
    $fatal(1, "timeout");
  end

  // directed sequence
  initial begin
    int a0, a1, a2, ra, wa, rb;
    wr_req_valid = 0;
    wr_req_addr = '0;
    wr_req_data = '0;
    wr_req_strb = '0;
    wr_req_prot = '0;
    rd_req_valid = 0;
    rd_req_addr = '0;
    rd_req_prot = '0;

    repeat (3) @(negedge ACLK);
    chk("reset valid/ready",
        64'({AWVALID, WVALID, BREADY,
             ARVALID, RREADY}), 0);
    chk("reset done/tmo",
        64'({wr_done, rd_done, tmo_err}), 0);
    chk("reset addr", 64'({AWADDR, ARADDR}), 0);
    chk("reset data", 64'({WDATA, rd_data}), 0);
    chk("reset resp", 64'({wr_resp, rd_resp}), 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("req_ready after reset",
        64'({wr_req_ready, rd_req_ready}), 2'b11);

    // zero-wait write: done two edges after acceptance
    wr_cmd(32'h0000_1000, 32'hDEAD_BEEF, 4'hF,
           3'b000, OKAY, 2, 1, a0);
    drain();

    // back-to-back writes: one every three cycles
    b_code = EXOKAY;
    wr_cmd(32'h0000_1004, 32'h0000_00AA, 4'h3,
           3'b010, EXOKAY, 2, 1, a1);
    wr_cmd(32'h0000_1008, 32'h0000_00BB, 4'hC,
           3'b101, EXOKAY, 2, 1, a2);
    chk("write b2b spacing", 64'(a2 - a1), 3);
    drain();

    // AWREADY late by 3 cycles, WREADY immediate
    aw_dly = 3;
    b_code = DECERR;
    wr_cmd(32'h0000_100C, 32'hA5A5_5A5A, 4'h1,
           3'b001, DECERR, 5, 1, a0);
    drain();
    aw_dly = 0;
    b_code = OKAY;

    // read with 5-cycle RVALID delay and SLVERR
    r_dly = 5;
    r_word = 32'h1234_5678;
    r_code = SLVERR;
    rd_cmd(32'h0000_2000, 3'b000, 32'h1234_5678,
           SLVERR, 7, ra);
    drain();
    r_dly = 0;

    // back-to-back zero-wait reads
    r_word = 32'hCAFE_F00D;
    r_code = OKAY;
    rd_cmd(32'h0000_2004, 3'b011, 32'hCAFE_F00D,
           OKAY, 2, ra);
    rd_cmd(32'h0000_2008, 3'b100, 32'hCAFE_F00D,
           OKAY, 2, rb);
    chk("read b2b spacing", 64'(rb - ra), 3);
    drain();

    // write and read issued in the same cycle
    r_word = 32'h0BAD_CAFE;
    fork
      wr_cmd(32'h0000_3000, 32'h1111_2222, 4'hF,
             3'b000, OKAY, 2, 1, wa);
      rd_cmd(32'h0000_3004, 3'b000, 32'h0BAD_CAFE,
             OKAY, 2, ra);
    join
    chk("concurrent accept", 64'(ra), 64'(wa));
    drain();

    // read accepted while a write waits on BVALID
    b_dly = 12;
    r_word = 32'h5555_AAAA;
    wr_cmd(32'h0000_3010, 32'h3333_4444, 4'hF,
           3'b000, OKAY, 14, 1, wa);
    rd_cmd(32'h0000_3014, 3'b000, 32'h5555_AAAA,
           OKAY, 2, ra);
    chk("rd accept during write", 64'(ra - wa), 1);
    drain();

    // long BVALID stall: watchdog only when compiled in
    b_dly = 30;
    wr_cmd(32'h0000_4000, 32'h7777_8888, 4'hF,
           3'b000, OKAY, 32, 1, wa);
    drain();
`ifdef AXIL_MASTER_WDOG_EN
    chk("tmo_err sticky", 64'(tmo_err), 1);
`else
    chk("tmo_err tied low", 64'(tmo_err), 0);
`endif

    // reset while waiting in W_RESP: no completion
    b_dly = 1000;
    wr_cmd(32'h0000_5000, 32'h9999_0000, 4'hF,
           3'b000, OKAY, -1, 0, wa);
    @(negedge ACLK);
    @(negedge ACLK);
    chk("BREADY in W_RESP", 64'(BREADY), 1);
    #2 ARESETn = 1'b0;
    #1;
    chk("mid reset outs",
        64'({BREADY, AWVALID, WVALID,
             wr_done, tmo_err}), 0);
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
    #1;
    chk("after reset BREADY", 64'(BREADY), 0);
    chk("after reset wr_req_ready",
        64'(wr_req_ready), 1);
    repeat (6) @(negedge ACLK);
    b_dly = 0;

    // engine usable again after reset
    wr_cmd(32'h0000_6000, 32'hFEED_FACE, 4'hF,
           3'b000, OKAY, 2, 1, wa);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_master_ctrl.md
# axil_master_ctrl

Parametrised AXI4-Lite master engine that turns simple valid/ready command requests into fully handshaked AXI4-Lite transactions. It has independent read and write engines, each with one outstanding transaction, so a read and a write may be in flight concurrently. It sits between local control logic and the AXI4-Lite interconnect. It replaces fixed-address, fixed-width masters with configurable address and data widths, per-request address, strobes and protection, and returned responses.

## Interface
- ADDR_W, 32, address width for AWADDR/ARADDR and the request address.
- DATA_W, 32, data width; legal values are 32 and 64. STRB_W = DATA_W/8 is derived, not overridable.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only when the watchdog is compiled in.
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- wr_req_valid / wr_req_ready  in/out  1  write command handshake.
- wr_req_addr, wr_req_data, wr_req_strb, wr_req_prot  in  ADDR_W, DATA_W, STRB_W, 3  write command fields.
- wr_done  out  1  one-cycle completion pulse; wr_resp  out  2  BRESP of the completed write.
- rd_req_valid / rd_req_ready  in/out  1  read command handshake.
- rd_req_addr, rd_req_prot  in  ADDR_W, 3  read command fields.
- rd_done  out  1  completion pulse; rd_data  out  DATA_W; rd_resp  out  2.
- AWVALID/AWREADY, AWADDR, AWPROT; WVALID/WREADY, WDATA, WSTRB; BVALID/BREADY, BRESP: standard AXI4-Lite write channels. Direction follows the master role; widths are ADDR_W, 3, DATA_W, STRB_W, 2.
- ARVALID/ARREADY, ARADDR, ARPROT; RVALID/RREADY, RDATA, RRESP: standard AXI4-Lite read channels.
- tmo_err  out  1  sticky watchdog flag, cleared only by reset.

## Operation
- Write FSM: W_IDLE -> W_REQ -> W_RESP -> W_IDLE.
  - In W_IDLE, wr_req_ready=1. On a request handshake, capture all fields and go to W_REQ.
  - In W_REQ, AWVALID and WVALID are driven high independently. Flags aw_done/w_done set on their own handshakes and drop the matching VALID the next cycle. When both flags are set, go to W_RESP. If both handshakes land in the same cycle, go straight to W_RESP.
  - In W_RESP, BREADY=1. On BVALID&BREADY, register BRESP into wr_resp, pulse wr_done, and go to W_IDLE.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - In R_IDLE, rd_req_ready=1.
  - In R_ADDR, ARVALID=1 until ARREADY.
  - In R_DATA, RREADY=1. On RVALID&RREADY, register RDATA/RRESP and pulse rd_done.
- VALID, once asserted, holds with stable payload until its handshake. VALID never depends combinationally on READY.
- The read and write engines never stall each other.
- Response codes are passed through unmodified (OKAY/EXOKAY/SLVERR/DECERR). The engine does not retry.
- rd_data/wr_resp hold their value until the next completion.

## Timing
- Reset values: all VALID/READY outputs and wr_done/rd_done = 0; addresses, data, resp, rd_data = 0; tmo_err = 0; FSMs in IDLE.
- wr_req_ready/rd_req_ready = 1 immediately after reset.
- Request accepted at edge T: AWVALID/WVALID, or ARVALID, are high from T+1.
- Zero-wait-state slave: write handshakes at T+1, BREADY from T+2, B handshake at T+2, wr_done at T+3. The read follows the same shape: rd_done at T+3.
- A new request can be accepted in the cycle wr_done/rd_done is high (IDLE is re-entered on that edge). Back-to-back throughput is one transaction per 3 cycles per channel.
- Reset asserted mid-transaction: all outputs go to reset values asynchronously, with no completion pulse. The interconnect is reset on the same ARESETn.

## Configuration
- AXIL_MASTER_WDOG_EN defined:
  - Each engine has a counter that increments every cycle spent outside IDLE and clears on IDLE entry.
  - When the count reaches TIMEOUT_CYC, tmo_err sets (sticky).
  - The transaction keeps waiting; AXI VALID is never withdrawn.
- AXIL_MASTER_WDOG_EN undefined: no counters are built and tmo_err is tied to 0.

## Structure
- The shared package axil_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - wr_state_t and rd_state_t enums.
  - the default PROT constant 3'b000.
- Sub-module axil_wdog holds a counter and sticky flag parameterised by TIMEOUT_CYC. It is instantiated once per engine under the macro, and the two flags are ORed into tmo_err.

## Test plan
- Write 0x0000_1000 <- 0xDEAD_BEEF, strb 4'hF, zero-wait slave -> AW and W handshakes at T+1, wr_done at T+3, wr_resp=OKAY.
- Slave delays AWREADY by 3 cycles while WREADY is immediate -> WVALID drops at T+2, AWVALID holds with stable AWADDR until its handshake, BREADY only after both handshakes, single wr_done.
- Read 0x0000_2000 while the slave returns RDATA=0x1234_5678 with RRESP=SLVERR after a 5-cycle RVALID delay -> rd_data=0x1234_5678, rd_resp=2'b10, one rd_done pulse.
- Concurrent write and read issued the same cycle -> both complete independently. Neither req_ready drops because of the other engine.
- ARESETn low while in W_RESP -> BREADY=0 and wr_req_ready=1 after release, no wr_done.
- With AXIL_MASTER_WDOG_EN and TIMEOUT_CYC=16, BVALID withheld -> tmo_err rises after 16 cycles in a non-IDLE state and stays high after a late BVALID completes the write.
